// File: rtl/pipe_pc_sequencer_if.sv
// Fetch-stage next-PC bus: redirect/stall requests into the sequencer,
// PC and pipeline control qualifiers back out to the pipeline.
interface pipe_pc_sequencer_if #(
   parameter int AW = 32
);
   logic          stall;
   logic          br_taken;
   logic [AW-1:0] br_target;
   logic          jump;
   logic [AW-1:0] j_target;
   logic          imem_ready;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc_4;
   logic          fetch_valid;
   logic          flush_if_id;
   logic          flush_id_ex;
   logic          misalign_err;
   logic [1:0]    state;

   // Sequencer side: consumes requests, produces PC and flush controls
   modport master (
      input  stall, br_taken, br_target, jump, j_target, imem_ready,
      output pc, pc_4, fetch_valid, flush_if_id, flush_id_ex, misalign_err, state
   );

   // Pipeline side: raises requests, consumes PC and flush controls
   modport slave (
      output stall, br_taken, br_target, jump, j_target, imem_ready,
      input  pc, pc_4, fetch_valid, flush_if_id, flush_id_ex, misalign_err, state
   );
endinterface

// File: rtl/pipe_pc_sequencer.sv
// Next-PC controller for the fetch stage of a 5-stage pipeline.
// Chooses between reset vector, EX branch redirect, ID jump, hold and PC+4,
// and produces the fetch qualifier and registered IF/ID, ID/EX flush pulses.
module pipe_pc_sequencer #(
   parameter int            AW       = 32,
   parameter logic [AW-1:0] RESET_PC = 32'h0000_3000
) (
   input logic               clk,
   input logic               rst,
   pipe_pc_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      HOLD  = 2'd2,
      REDIR = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic          flush_if_id_q, flush_if_id_d;
   logic          flush_id_ex_q, flush_id_ex_d;
   logic          misalign_err_q, misalign_err_d;

   logic          take_br;
   logic          take_j;
   logic [AW-1:0] redir_target;

   // Next-state / next-PC selection; a branch always outranks everything,
   // a jump only lands when no stall is pending, since ID re-presents it later
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      flush_if_id_d  = 1'b0;
      flush_id_ex_d  = 1'b0;
      misalign_err_d = misalign_err_q;
      take_br        = 1'b0;
      take_j         = 1'b0;
      redir_target   = '0;

      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (bus.br_taken)         take_br = 1'b1;
            else if (bus.stall)       state_d = HOLD;
            else if (bus.jump)        take_j  = 1'b1;
            else if (!bus.imem_ready) state_d = HOLD;
            else                      pc_d    = pc_q + {{(AW-3){1'b0}}, 3'd4};
         end
         HOLD: begin
            if (bus.br_taken)                       take_br = 1'b1;
            else if (!bus.stall && bus.jump)        take_j  = 1'b1;
            else if (!bus.stall && bus.imem_ready)  state_d = RUN;
         end
         REDIR: begin
            if (bus.br_taken) take_br = 1'b1;
            else              state_d = RUN;
         end
         default: state_d = BOOT;
      endcase

      if (take_br) begin
         redir_target  = bus.br_target;
         flush_if_id_d = 1'b1;
         flush_id_ex_d = 1'b1;
      end else if (take_j) begin
         redir_target  = bus.j_target;
         flush_if_id_d = 1'b1;
      end

      if (take_br || take_j) begin
         state_d = REDIR;
         pc_d    = {redir_target[AW-1:2], 2'b00};
         if (redir_target[1:0] != 2'b00) misalign_err_d = 1'b1;
      end
   end

   // State, PC and registered control outputs; reset returns to BOOT at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= BOOT;
         pc_q           <= RESET_PC;
         flush_if_id_q  <= 1'b0;
         flush_id_ex_q  <= 1'b0;
         misalign_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         flush_if_id_q  <= flush_if_id_d;
         flush_id_ex_q  <= flush_id_ex_d;
         misalign_err_q <= misalign_err_d;
      end
   end

   assign bus.pc           = pc_q;
   assign bus.pc_4         = pc_q + {{(AW-3){1'b0}}, 3'd4};
   assign bus.fetch_valid  = (state_q == RUN) && bus.imem_ready && !bus.stall;
   assign bus.flush_if_id  = flush_if_id_q;
   assign bus.flush_id_ex  = flush_id_ex_q;
   assign bus.misalign_err = misalign_err_q;
   assign bus.state        = state_q;

endmodule

// File: tb/tb_pipe_pc_sequencer.sv
// Directed testbench for pipe_pc_sequencer: every expected value below is
// hand-computed from the intended PC sequencing behaviour.
module tb_pipe_pc_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   pipe_pc_sequencer_if #(.AW(32)) bus ();

   pipe_pc_sequencer #(.AW(32), .RESET_PC(32'h0000_3000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Safety net so a stuck run still ends with a report
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

   // Advance one clock and sample a little after the edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0;
      bus.jump = 1'b0; bus.j_target = '0; bus.imem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      checks++; if (bus.pc !== 32'h3000) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", bus.pc, 32'h3000); end
      checks++; if (bus.state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", bus.state); end
      checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fv: got %b expected 0", bus.fetch_valid); end
      checks++; if ({bus.flush_if_id, bus.flush_id_ex, bus.misalign_err} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {bus.flush_if_id, bus.flush_id_ex, bus.misalign_err}); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (bus.state !== 2'd0 || bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL boot: got state %0d fv %b expected 0/0", bus.state, bus.fetch_valid); end
      tick();
      checks++; if (bus.state !== 2'd1 || bus.pc !== 32'h3000 || bus.fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_run: got state %0d pc %h fv %b expected 1/3000/1", bus.state, bus.pc, bus.fetch_valid); end
      tick();
      checks++; if (bus.pc !== 32'h3004) begin errors++; $display("[TB] FAIL run_pc1: got %h expected 3004", bus.pc); end
      tick();
      checks++; if (bus.pc !== 32'h3008) begin errors++; $display("[TB] FAIL run_pc2: got %h expected 3008", bus.pc); end
   endtask

   task automatic test_stall();
      tick(); tick();
      checks++; if (bus.pc !== 32'h3010 || bus.state !== 2'd1) begin errors++; $display("[TB] FAIL stall_start: got pc %h state %0d expected 3010/1", bus.pc, bus.state); end
      bus.stall = 1'b1;
      #1;
      checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_fv_run: got %b expected 0", bus.fetch_valid); end
      tick();
      checks++; if (bus.state !== 2'd2 || bus.pc !== 32'h3010 || bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold1: got state %0d pc %h fv %b expected 2/3010/0", bus.state, bus.pc, bus.fetch_valid); end
      tick();
      bus.stall = 1'b0;
      #1;
      checks++; if (bus.state !== 2'd2 || bus.pc !== 32'h3010 || bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold2: got state %0d pc %h fv %b expected 2/3010/0", bus.state, bus.pc, bus.fetch_valid); end
      tick();
      checks++; if (bus.state !== 2'd1 || bus.pc !== 32'h3010 || bus.fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_exit: got state %0d pc %h fv %b expected 1/3010/1", bus.state, bus.pc, bus.fetch_valid); end
      tick();
      checks++; if (bus.pc !== 32'h3014) begin errors++; $display("[TB] FAIL stall_advance: got %h expected 3014", bus.pc); end
   endtask

   task automatic test_branch_jump();
      bus.br_taken = 1'b1; bus.br_target = 32'h3100;
      bus.jump = 1'b1; bus.j_target = 32'h3200;
      tick();
      bus.br_taken = 1'b0; bus.jump = 1'b0;
      #1;
      checks++; if (bus.state !== 2'd3 || bus.pc !== 32'h3100) begin errors++; $display("[TB] FAIL br_redirect: got state %0d pc %h expected 3/3100", bus.state, bus.pc); end
      checks++; if (bus.flush_if_id !== 1'b1 || bus.flush_id_ex !== 1'b1 || bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL br_flush: got %b%b fv %b expected 11 fv 0", bus.flush_if_id, bus.flush_id_ex, bus.fetch_valid); end
      tick();
      checks++; if (bus.state !== 2'd1 || bus.pc !== 32'h3100 || bus.flush_if_id !== 1'b0 || bus.flush_id_ex !== 1'b0) begin errors++; $display("[TB] FAIL br_bubble_end: got state %0d pc %h flush %b%b expected 1/3100/00", bus.state, bus.pc, bus.flush_if_id, bus.flush_id_ex); end
      tick();
      checks++; if (bus.pc !== 32'h3104) begin errors++; $display("[TB] FAIL br_advance: got %h expected 3104", bus.pc); end
   endtask

   task automatic test_jump_stall();
      bus.jump = 1'b1; bus.j_target = 32'h3200; bus.stall = 1'b1;
      tick();
      checks++; if (bus.state !== 2'd2 || bus.pc !== 32'h3104 || bus.flush_if_id !== 1'b0) begin errors++; $display("[TB] FAIL jmp_stall_hold: got state %0d pc %h fif %b expected 2/3104/0", bus.state, bus.pc, bus.flush_if_id); end
      bus.stall = 1'b0;
      tick();
      bus.jump = 1'b0;
      checks++; if (bus.state !== 2'd3 || bus.pc !== 32'h3200) begin errors++; $display("[TB] FAIL jmp_redirect: got state %0d pc %h expected 3/3200", bus.state, bus.pc); end
      checks++; if (bus.flush_if_id !== 1'b1 || bus.flush_id_ex !== 1'b0) begin errors++; $display("[TB] FAIL jmp_flush: got %b%b expected 10", bus.flush_if_id, bus.flush_id_ex); end
      tick();
      checks++; if (bus.state !== 2'd1 || bus.pc !== 32'h3200 || bus.flush_if_id !== 1'b0) begin errors++; $display("[TB] FAIL jmp_bubble_end: got state %0d pc %h fif %b expected 1/3200/0", bus.state, bus.pc, bus.flush_if_id); end
      tick();
      checks++; if (bus.pc !== 32'h3204) begin errors++; $display("[TB] FAIL jmp_advance: got %h expected 3204", bus.pc); end
   endtask

   task automatic test_misalign();
      checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("[TB] FAIL mis_clear: got %b expected 0", bus.misalign_err); end
      bus.br_taken = 1'b1; bus.br_target = 32'h3102;
      tick();
      bus.br_taken = 1'b0;
      checks++; if (bus.pc !== 32'h3100 || bus.misalign_err !== 1'b1) begin errors++; $display("[TB] FAIL mis_set: got pc %h err %b expected 3100/1", bus.pc, bus.misalign_err); end
      tick(); tick();
      checks++; if (bus.pc !== 32'h3104 || bus.misalign_err !== 1'b1) begin errors++; $display("[TB] FAIL mis_sticky: got pc %h err %b expected 3104/1", bus.pc, bus.misalign_err); end
   endtask

   task automatic test_imem_wait();
      bus.imem_ready = 1'b0;
      #1;
      checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_fv: got %b expected 0", bus.fetch_valid); end
      tick(); tick();
      checks++; if (bus.state !== 2'd2 || bus.pc !== 32'h3104) begin errors++; $display("[TB] FAIL wait_hold: got state %0d pc %h expected 2/3104", bus.state, bus.pc); end
      bus.br_taken = 1'b1; bus.br_target = 32'h3300;
      tick();
      bus.br_taken = 1'b0; bus.imem_ready = 1'b1;
      checks++; if (bus.state !== 2'd3 || bus.pc !== 32'h3300 || bus.flush_id_ex !== 1'b1) begin errors++; $display("[TB] FAIL wait_redirect: got state %0d pc %h fie %b expected 3/3300/1", bus.state, bus.pc, bus.flush_id_ex); end
      tick(); tick();
      checks++; if (bus.pc !== 32'h3304 || bus.misalign_err !== 1'b1) begin errors++; $display("[TB] FAIL wait_resume: got pc %h err %b expected 3304/1", bus.pc, bus.misalign_err); end
   endtask

   task automatic test_wrap_and_reset();
      bus.jump = 1'b1; bus.j_target = 32'hFFFF_FFFC;
      tick();
      bus.jump = 1'b0;
      checks++; if (bus.pc !== 32'hFFFF_FFFC || bus.pc_4 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc4: got pc %h pc_4 %h expected fffffffc/0", bus.pc, bus.pc_4); end
      tick(); tick();
      checks++; if (bus.pc !== 32'h0 || bus.pc_4 !== 32'h4) begin errors++; $display("[TB] FAIL wrap_pc: got pc %h pc_4 %h expected 0/4", bus.pc, bus.pc_4); end
      bus.br_taken = 1'b1; bus.br_target = 32'h4000;
      tick();
      bus.br_taken = 1'b0;
      checks++; if (bus.state !== 2'd3 || bus.flush_id_ex !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_redir: got state %0d fie %b expected 3/1", bus.state, bus.flush_id_ex); end
      rst = 1'b0;
      #1;
      checks++; if (bus.pc !== 32'h3000 || bus.state !== 2'd0) begin errors++; $display("[TB] FAIL midreset: got pc %h state %0d expected 3000/0", bus.pc, bus.state); end
      checks++; if ({bus.flush_if_id, bus.flush_id_ex, bus.misalign_err} !== 3'b000) begin errors++; $display("[TB] FAIL midreset_flags: got %b expected 000", {bus.flush_if_id, bus.flush_id_ex, bus.misalign_err}); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_back_to_back();
      tick();
      checks++; if (bus.state !== 2'd1 || bus.pc !== 32'h3000) begin errors++; $display("[TB] FAIL b2b_start: got state %0d pc %h expected 1/3000", bus.state, bus.pc); end
      bus.br_taken = 1'b1; bus.br_target = 32'h3500;
      tick();
      bus.br_target = 32'h3600;
      checks++; if (bus.pc !== 32'h3500 || bus.flush_id_ex !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first: got pc %h fie %b expected 3500/1", bus.pc, bus.flush_id_ex); end
      tick();
      bus.br_taken = 1'b0;
      checks++; if (bus.state !== 2'd3 || bus.pc !== 32'h3600 || bus.flush_if_id !== 1'b1 || bus.flush_id_ex !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second: got state %0d pc %h flush %b%b expected 3/3600/11", bus.state, bus.pc, bus.flush_if_id, bus.flush_id_ex); end
      tick();
      checks++; if (bus.state !== 2'd1 || bus.pc !== 32'h3600 || bus.flush_if_id !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end: got state %0d pc %h fif %b expected 1/3600/0", bus.state, bus.pc, bus.flush_if_id); end
      tick();
      checks++; if (bus.pc !== 32'h3604) begin errors++; $display("[TB] FAIL b2b_advance: got %h expected 3604", bus.pc); end
   endtask

   // Scenario sequence; each task picks up from the state the previous left
   initial begin
      test_reset();
      test_stall();
      test_branch_jump();
      test_jump_stall();
      test_misalign();
      test_imem_wait();
      test_wrap_and_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
